axi_chan_fifo_bank: RTL and testbench
=====================================

Name: axi_chan_fifo_bank

Overview:
- Single-clock, parametrised bank of N independent valid/ready FIFOs, one per AXI channel (AW, W, B, AR, R when N=5), with channel payloads packed as flat vectors.
- It is the same-clock counterpart to our AXI clock-domain crossing and sits between the flattened AXI ports of the vector cluster and the interconnect.
- Over a plain register slice it adds per-channel depth, an optional fall-through mode, occupancy and almost-full reporting, and a synchronous flush.

Parameters:
NUM_CH, 5, number of independent channels.
DATA_W, 64, payload width per channel; narrower channels are zero-padded by the instantiator.
LOG_DEPTH, 1, each FIFO holds 2**LOG_DEPTH entries; legal range 0..6 (0 = single entry).
FALL_THROUGH, 0, 1 = an empty FIFO passes input to output in the same cycle.
AFULL_TH, 1, almost-full asserts when usage >= AFULL_TH; legal range 1..2**LOG_DEPTH.

Ports:
clk_i  in  1  clock.
rst_ni  in  1  reset, asynchronous, active-low.
flush_i  in  1  synchronous clear of all FIFOs.
slv_valid_i  in  NUM_CH  per-channel input valid.
slv_ready_o  out  NUM_CH  per-channel input ready.
slv_data_i  in  NUM_CH*DATA_W  packed payload in; channel c occupies bits [c*DATA_W +: DATA_W].
mst_valid_o  out  NUM_CH  per-channel output valid.
mst_ready_i  in  NUM_CH  per-channel output ready.
mst_data_o  out  NUM_CH*DATA_W  packed payload out, same packing as slv_data_i.
usage_o  out  NUM_CH*(LOG_DEPTH+1)  per-channel occupancy, packed like the data vectors.
afull_o  out  NUM_CH  per-channel almost-full flag.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values: all FIFOs empty; mst_valid_o=0, usage_o=0, afull_o=0, mst_data_o=0; slv_ready_o=all ones one cycle after deassertion (0 while rst_ni=0); pointers and storage cleared to 0.
- Channel independence: channels are fully independent; there is no ordering or coupling between them.
- Ready: slv_ready_o[c] = !full[c] && !flush_i. It is registered and has no combinational path from mst_ready_i.
  - A full FIFO does not accept a push in the same cycle it pops; ready re-asserts in the following cycle.
- Push/pop: push = valid && ready on the slave side; pop = mst_valid && mst_ready on the master side.
  - usage' = usage + push - pop, clamped by construction to 0..2**LOG_DEPTH.
- Latency with FALL_THROUGH=0: a push into an empty FIFO produces mst_valid_o at the next rising edge (1 cycle).
- Latency with FALL_THROUGH=1: an empty FIFO drives mst_valid_o = slv_valid_i and mst_data_o = slv_data_i combinationally (0 cycles).
  - If the data is popped in that same cycle, it is not written and usage stays 0.
  - If it is not popped, it is written normally.
- Output stability: mst_data_o is the head entry. Once mst_valid_o=1 it holds valid and data stable until a pop (AXI rule).
  - Exception: in fall-through mode with an empty FIFO, stability follows the upstream source.
- Pointers: binary read/write pointers of LOG_DEPTH bits, wrapping modulo 2**LOG_DEPTH. Full/empty are derived from usage, not from pointer equality.
- LOG_DEPTH=0: a single-entry buffer. Full throughput is not required; back-to-back pushes alternate with a 1-cycle bubble when FALL_THROUGH=0.
- Almost-full: afull_o[c] = (usage[c] >= AFULL_TH). It is a combinational function of the usage register.
- Flush: flush_i=1 at a rising edge empties every FIFO (usage=0, pointers=0); storage contents are not required to clear.
  - While flush_i=1: slv_ready_o=0 and mst_valid_o=0, and no push or pop is counted.
  - After flush_i falls, normal operation resumes the next cycle.
- Reset mid-transfer: in-flight entries are discarded and outputs go immediately (asynchronously) to their reset values.
- Assertions (simulation only):
  - no push while full;
  - no pop while empty;
  - mst_data_o stable while valid && !ready.

Test Plan:
1. NUM_CH=5, DATA_W=8, LOG_DEPTH=1, FT=0: push 0xA1,0xA2 on ch0 with mst_ready=0 -> usage=2, afull=1, slv_ready[0]=0; release ready -> 0xA1 then 0xA2 on consecutive cycles, usage returns to 0.
2. FT=1, empty ch2, slv_valid=1 with 0x5C and mst_ready=1 in the same cycle -> mst_valid=1 and data 0x5C in the same cycle, usage stays 0.
3. Full ch1 (2 entries), pop and offer push in the same cycle -> push refused (ready=0), usage=1 next cycle, ready=1 next cycle; then push 0x33 -> usage=2.
4. Wrap-around: stream 0x00..0x0F through ch4 with random mst_ready stalls (LOG_DEPTH=2) -> output order identical, no loss or duplication, usage never exceeds 4.
5. Flush with ch0=2 and ch3=1 entries -> next cycle all usage=0, mst_valid=0; during flush slv_ready=0; the first push after flush emerges first.
6. Assert rst_ni asynchronously mid-burst on ch2 -> mst_valid_o and usage_o go to 0 without a clock edge; slv_ready_o=all ones one cycle after release.

Source files
------------

// File: rtl/axi_chan_fifo_bank.sv
// Bank of independent single-clock valid/ready FIFOs, one per AXI channel.
// Payloads, occupancies and flags are packed per channel into flat vectors.
module axi_chan_fifo_bank #(
    parameter int unsigned NUM_CH       = 5,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned LOG_DEPTH    = 1,
    parameter int unsigned FALL_THROUGH = 0,
    parameter int unsigned AFULL_TH     = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            flush_i,
    input  logic [NUM_CH-1:0]               slv_valid_i,
    output logic [NUM_CH-1:0]               slv_ready_o,
    input  logic [NUM_CH*DATA_W-1:0]        slv_data_i,
    output logic [NUM_CH-1:0]               mst_valid_o,
    input  logic [NUM_CH-1:0]               mst_ready_i,
    output logic [NUM_CH*DATA_W-1:0]        mst_data_o,
    output logic [NUM_CH*(LOG_DEPTH+1)-1:0] usage_o,
    output logic [NUM_CH-1:0]               afull_o
);

    localparam int DEPTH = 1 << LOG_DEPTH;
    localparam int UW    = int'(LOG_DEPTH) + 1;
    localparam int PTR_W = (LOG_DEPTH > 0) ? int'(LOG_DEPTH) : 1;

    // Pointers wrap at DEPTH; for a single-entry buffer they stay at zero.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    for (genvar gi = 0; gi < int'(NUM_CH); gi++) begin : g_ch
        logic [UW-1:0]     usage_q, usage_d;
        logic [PTR_W-1:0]  wptr_q, wptr_d;
        logic [PTR_W-1:0]  rptr_q, rptr_d;
        logic              ready_q, ready_d;
        logic [DATA_W-1:0] mem_q [DEPTH];

        logic [DATA_W-1:0] slv_data;
        logic [DATA_W-1:0] head_data;
        logic              empty, full;
        logic              slv_rdy, byp_valid, bypass;
        logic              push, pop, write_en, pop_head;

        assign slv_data  = slv_data_i[gi*DATA_W +: DATA_W];
        assign head_data = mem_q[rptr_q];
        assign empty     = (usage_q == '0);
        assign full      = (usage_q == UW'(DEPTH));

        // ready_q is a pure register so slv_ready_o never depends on mst_ready_i.
        assign slv_rdy   = ready_q & ~flush_i;
        assign bypass    = (FALL_THROUGH != 0) && empty;
        assign byp_valid = slv_valid_i[gi] & slv_rdy;

        always_comb begin
            mst_valid_o[gi] = 1'b0;
            if (!flush_i) begin
                mst_valid_o[gi] = bypass ? byp_valid : !empty;
            end
        end

        assign mst_data_o[gi*DATA_W +: DATA_W] = (bypass && byp_valid) ? slv_data : head_data;
        assign slv_ready_o[gi]                 = slv_rdy;
        assign usage_o[gi*UW +: UW]            = usage_q;
        assign afull_o[gi]                     = (usage_q >= UW'(AFULL_TH));

        assign push     = slv_valid_i[gi] & slv_rdy;
        assign pop      = mst_valid_o[gi] & mst_ready_i[gi];
        // A bypassed beat consumed in the same cycle never touches storage.
        assign write_en = push && !(bypass && pop);
        assign pop_head = pop && !empty;

        always_comb begin
            usage_d = usage_q;
            wptr_d  = wptr_q;
            rptr_d  = rptr_q;
            if (flush_i) begin
                usage_d = '0;
                wptr_d  = '0;
                rptr_d  = '0;
            end else begin
                usage_d = usage_q + UW'(write_en) - UW'(pop_head);
                if (write_en) begin
                    wptr_d = ptr_inc(wptr_q);
                end
                if (pop_head) begin
                    rptr_d = ptr_inc(rptr_q);
                end
            end
            ready_d = (usage_d != UW'(DEPTH));
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                usage_q <= '0;
                wptr_q  <= '0;
                rptr_q  <= '0;
                ready_q <= 1'b0;
            end else begin
                usage_q <= usage_d;
                wptr_q  <= wptr_d;
                rptr_q  <= rptr_d;
                ready_q <= ready_d;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[i] <= '0;
                end
            end else if (write_en) begin
                mem_q[wptr_q] <= slv_data;
            end
        end

        a_no_push_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
            push |-> !full);
        a_no_pop_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
            (pop && empty) |-> (FALL_THROUGH != 0));
        a_data_stable  : assert property (@(posedge clk_i) disable iff (!rst_ni)
            (mst_valid_o[gi] && !mst_ready_i[gi] && !empty && !flush_i)
            |=> (flush_i || (mst_valid_o[gi] && $stable(mst_data_o[gi*DATA_W +: DATA_W]))));
    end

endmodule

// File: tb/tb_axi_chan_fifo_bank.sv
// Bench for axi_chan_fifo_bank: two instances (depth 2 registered, depth 4 fall-through)
// checked every cycle against queue models, plus directed literal expectations.
module tb_axi_chan_fifo_bank;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush   [2];
    logic [4:0]  s_valid [2];
    logic [4:0]  s_ready [2];
    logic [4:0]  m_valid [2];
    logic [4:0]  m_ready [2];
    logic [4:0]  afull   [2];
    logic [39:0] s_data  [2];
    logic [39:0] m_data  [2];
    logic [9:0]  usage_a;
    logic [14:0] usage_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axi_chan_fifo_bank #(
        .NUM_CH(5), .DATA_W(8), .LOG_DEPTH(1), .FALL_THROUGH(0), .AFULL_TH(2)
    ) u_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[0]),
        .slv_valid_i(s_valid[0]), .slv_ready_o(s_ready[0]), .slv_data_i(s_data[0]),
        .mst_valid_o(m_valid[0]), .mst_ready_i(m_ready[0]), .mst_data_o(m_data[0]),
        .usage_o(usage_a), .afull_o(afull[0])
    );

    axi_chan_fifo_bank #(
        .NUM_CH(5), .DATA_W(8), .LOG_DEPTH(2), .FALL_THROUGH(1), .AFULL_TH(3)
    ) u_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[1]),
        .slv_valid_i(s_valid[1]), .slv_ready_o(s_ready[1]), .slv_data_i(s_data[1]),
        .mst_valid_o(m_valid[1]), .mst_ready_i(m_ready[1]), .mst_data_o(m_data[1]),
        .usage_o(usage_b), .afull_o(afull[1])
    );

    function automatic int depth_of(input int i);
        return (i == 0) ? 2 : 4;
    endfunction
    function automatic bit ft_of(input int i);
        return (i == 1);
    endfunction
    function automatic int th_of(input int i);
        return (i == 0) ? 2 : 3;
    endfunction
    function automatic int get_usage(input int i, input int c);
        if (i == 0) return int'(usage_a[c*2 +: 2]);
        return int'(usage_b[c*3 +: 3]);
    endfunction

    task automatic check(input string nm, input int inst, input int ch,
                         input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d ch=%0d got=%0h want=%0h t=%0t", nm, inst, ch, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: one queue per channel; ready is "not full and not flushing",
    // available from the first edge after reset release.
    logic [7:0] qs [10][$];
    bit         pend_push [10];
    bit         pend_pop  [10];
    logic [7:0] pend_dat  [10];
    bit         started = 1'b0;

    int         k, sz;
    bit         er, ev;
    logic [7:0] ed;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 5; c++) begin
                k = i * 5 + c;
                if (!rst_n) begin
                    check("rst_valid", i, c, 32'(m_valid[i][c]), 0);
                    check("rst_ready", i, c, 32'(s_ready[i][c]), 0);
                    check("rst_usage", i, c, get_usage(i, c), 0);
                    check("rst_afull", i, c, 32'(afull[i][c]), 0);
                    check("rst_data", i, c, 32'(m_data[i][c*8 +: 8]), 0);
                    pend_push[k] = 1'b0;
                    pend_pop[k]  = 1'b0;
                end else begin
                    sz = qs[k].size();
                    er = started && (sz < depth_of(i)) && !flush[i];
                    ev = !flush[i] && ((sz > 0) || (ft_of(i) && s_valid[i][c] && er));
                    ed = (sz > 0) ? qs[k][0] : s_data[i][c*8 +: 8];
                    check("ready", i, c, 32'(s_ready[i][c]), 32'(er));
                    check("valid", i, c, 32'(m_valid[i][c]), 32'(ev));
                    check("usage", i, c, get_usage(i, c), sz);
                    check("afull", i, c, 32'(afull[i][c]), 32'(sz >= th_of(i)));
                    if (ev) check("data", i, c, 32'(m_data[i][c*8 +: 8]), 32'(ed));
                    pend_push[k] = s_valid[i][c] && er;
                    pend_dat[k]  = s_data[i][c*8 +: 8];
                    pend_pop[k]  = ev && m_ready[i][c];
                end
            end
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int j = 0; j < 10; j++) qs[j].delete();
            started = 1'b0;
        end else begin
            for (int j = 0; j < 10; j++) begin
                if (flush[j / 5]) begin
                    qs[j].delete();
                end else begin
                    if (pend_push[j]) qs[j].push_back(pend_dat[j]);
                    if (pend_pop[j]) begin
                        $display("inst %0d ch %0d pop %02h", j / 5, j % 5, qs[j][0]);
                        void'(qs[j].pop_front());
                    end
                end
            end
            started = 1'b1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rx [$];
        int sent, cyc, maxu;
        bit did_push;

        for (int i = 0; i < 2; i++) begin
            flush[i] = 1'b0; s_valid[i] = '0; m_ready[i] = '0; s_data[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("lit_rst_ready", 0, -1, 32'(s_ready[0]), 0);
        check("lit_rst_usage", 0, -1, 32'(usage_a), 0);
        check("lit_rst_mvalid", 1, -1, 32'(m_valid[1]), 0);
        rst_n = 1'b1;
        tick();
        check("lit_ready_after_rst", 0, -1, 32'(s_ready[0]), 32'h1f);
        check("lit_ready_after_rst", 1, -1, 32'(s_ready[1]), 32'h1f);

        // Two pushes on ch0 while stalled, then drain.
        s_valid[0][0] = 1'b1; s_data[0][7:0] = 8'hA1;
        tick();
        check("lit_t1_usage1", 0, 0, get_usage(0, 0), 1);
        check("lit_t1_afull0", 0, 0, 32'(afull[0][0]), 0);
        s_data[0][7:0] = 8'hA2;
        tick();
        s_valid[0][0] = 1'b0;
        check("lit_t1_usage2", 0, 0, get_usage(0, 0), 2);
        check("lit_t1_afull1", 0, 0, 32'(afull[0][0]), 1);
        check("lit_t1_ready0", 0, 0, 32'(s_ready[0][0]), 0);
        check("lit_t1_head", 0, 0, 32'(m_data[0][7:0]), 32'hA1);
        m_ready[0][0] = 1'b1;
        tick();
        check("lit_t1_second", 0, 0, 32'(m_data[0][7:0]), 32'hA2);
        check("lit_t1_valid", 0, 0, 32'(m_valid[0][0]), 1);
        tick();
        check("lit_t1_empty", 0, 0, get_usage(0, 0), 0);
        m_ready[0][0] = 1'b0;

        // Fall-through bypass on an empty channel.
        s_valid[1][2] = 1'b1; s_data[1][23:16] = 8'h5C; m_ready[1][2] = 1'b1;
        #1;
        check("lit_t2_valid", 1, 2, 32'(m_valid[1][2]), 1);
        check("lit_t2_data", 1, 2, 32'(m_data[1][23:16]), 32'h5C);
        tick();
        check("lit_t2_usage", 1, 2, get_usage(1, 2), 0);
        s_valid[1][2] = 1'b0; m_ready[1][2] = 1'b0;

        // Full channel: pop and offered push in the same cycle.
        s_valid[0][1] = 1'b1; s_data[0][15:8] = 8'h11;
        tick();
        s_data[0][15:8] = 8'h22;
        tick();
        check("lit_t3_full_ready", 0, 1, 32'(s_ready[0][1]), 0);
        s_data[0][15:8] = 8'h33; m_ready[0][1] = 1'b1;
        tick();
        check("lit_t3_usage1", 0, 1, get_usage(0, 1), 1);
        check("lit_t3_ready1", 0, 1, 32'(s_ready[0][1]), 1);
        check("lit_t3_head", 0, 1, 32'(m_data[0][15:8]), 32'h22);
        m_ready[0][1] = 1'b0;
        tick();
        s_valid[0][1] = 1'b0;
        check("lit_t3_usage2", 0, 1, get_usage(0, 1), 2);
        m_ready[0][1] = 1'b1;
        tick();
        tick();
        m_ready[0][1] = 1'b0;
        check("lit_t3_drained", 0, 1, get_usage(0, 1), 0);

        // Stream 0x00..0x0F through a depth-4 channel with stalls.
        sent = 0; cyc = 0; maxu = 0;
        while (rx.size() < 16 && cyc < 400) begin
            s_valid[1][4]    = (sent < 16);
            s_data[1][39:32] = 8'(sent);
            m_ready[1][4]    = (cyc < 6) ? 1'b0 : 1'($urandom_range(0, 1));
            @(negedge clk);
            did_push = s_valid[1][4] && s_ready[1][4];
            if (m_valid[1][4] && m_ready[1][4]) rx.push_back(m_data[1][39:32]);
            if (get_usage(1, 4) > maxu) maxu = get_usage(1, 4);
            tick();
            if (did_push) sent++;
            cyc++;
        end
        s_valid[1][4] = 1'b0; m_ready[1][4] = 1'b0;
        check("lit_t4_count", 1, 4, rx.size(), 16);
        for (int i = 0; i < 16 && i < rx.size(); i++) check("lit_t4_order", 1, 4, 32'(rx[i]), i);
        check("lit_t4_max_le4", 1, 4, 32'(maxu <= 4), 1);
        check("lit_t4_filled", 1, 4, maxu, 4);

        // Flush with ch0=2, ch3=1.
        s_valid[0][0] = 1'b1; s_data[0][7:0] = 8'h01;
        s_valid[0][3] = 1'b1; s_data[0][31:24] = 8'h31;
        tick();
        s_valid[0][3] = 1'b0; s_data[0][7:0] = 8'h02;
        tick();
        s_valid[0][0] = 1'b0;
        check("lit_t5_u0", 0, 0, get_usage(0, 0), 2);
        check("lit_t5_u3", 0, 3, get_usage(0, 3), 1);
        flush[0] = 1'b1; s_valid[0][0] = 1'b1; s_data[0][7:0] = 8'h55;
        #1;
        check("lit_t5_ready_fl", 0, -1, 32'(s_ready[0]), 0);
        check("lit_t5_valid_fl", 0, -1, 32'(m_valid[0]), 0);
        tick();
        check("lit_t5_usage_fl", 0, -1, 32'(usage_a), 0);
        flush[0] = 1'b0; s_data[0][7:0] = 8'h77;
        tick();
        s_valid[0][0] = 1'b0;
        check("lit_t5_first", 0, 0, 32'(m_data[0][7:0]), 32'h77);
        check("lit_t5_valid", 0, 0, 32'(m_valid[0][0]), 1);
        check("lit_t5_usage", 0, 0, get_usage(0, 0), 1);
        m_ready[0][0] = 1'b1;
        tick();
        m_ready[0][0] = 1'b0;

        // Asynchronous reset in the middle of a burst on ch2.
        s_valid[0][2] = 1'b1; s_data[0][23:16] = 8'h21;
        tick();
        s_data[0][23:16] = 8'h22;
        tick();
        s_data[0][23:16] = 8'h23;
        #1;
        rst_n = 1'b0;
        #1;
        check("lit_t6_valid", 0, -1, 32'(m_valid[0]), 0);
        check("lit_t6_usage", 0, -1, 32'(usage_a), 0);
        check("lit_t6_ready", 0, -1, 32'(s_ready[0]), 0);
        check("lit_t6_data", 0, -1, 32'(m_data[0]), 0);
        s_valid[0][2] = 1'b0;
        @(posedge clk);
        tick();
        rst_n = 1'b1;
        check("lit_t6_ready_rel", 0, -1, 32'(s_ready[0]), 0);
        tick();
        check("lit_t6_ready_after", 0, -1, 32'(s_ready[0]), 32'h1f);
        check("lit_t6_ready_after", 1, -1, 32'(s_ready[1]), 32'h1f);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
